// File: rtl/trace_dump_pkg.sv
// Shared definitions for the trace readout path: FSM states, RAM geometry
// defaults and channel-select encodings.
package trace_dump_pkg;

    localparam int DEPTH_DEF  = 512;
    localparam int ADDR_W_DEF = 9;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        CORR,
        SEND,
        WAIT_TX,
        DONE
    } dump_state_t;

    // Encoding 3 is unused by the command processor and aliases channel 1.
    localparam logic [1:0] CH_SEL_1    = 2'd0;
    localparam logic [1:0] CH_SEL_2    = 2'd1;
    localparam logic [1:0] CH_SEL_3    = 2'd2;
    localparam logic [1:0] CH_SEL_ALT1 = 2'd3;

endpackage

// File: rtl/sample_corrector.sv
// Combinational offset/gain correction of one raw 8-bit sample, saturating
// to 0..255 after the offset add and again after the gain multiply.
module sample_corrector (
    input  logic [7:0] raw,
    input  logic [7:0] offset,
    input  logic [7:0] gain,
    output logic [7:0] corr
);

    logic [9:0]  sum;
    logic [7:0]  sum_clamp;
    logic [15:0] prod;
    logic [8:0]  scaled;

    always_comb begin
        // Range is -128..382, so bit 9 flags negative and bit 8 flags >255.
        sum = {2'b00, raw} + {{2{offset[7]}}, offset};
        if (sum[9]) begin
            sum_clamp = 8'h00;
        end else if (sum[8]) begin
            sum_clamp = 8'hFF;
        end else begin
            sum_clamp = sum[7:0];
        end
        prod   = {8'h00, sum_clamp} * {8'h00, gain};
        scaled = prod[15:7];
        corr   = scaled[8] ? 8'hFF : scaled[7:0];
    end

endmodule

// File: rtl/trace_dump.sv
// Reads one channel's circular sample RAM oldest-first after a capture,
// corrects each sample and hands the bytes to the transmitter one by one.
module trace_dump
    import trace_dump_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dump_start,
    input  logic [1:0]        ch_sel,
    input  logic [ADDR_W-1:0] trace_end,
    input  logic [7:0]        offset,
    input  logic [7:0]        gain,
    input  logic [7:0]        rdata_ch1,
    input  logic [7:0]        rdata_ch2,
    input  logic [7:0]        rdata_ch3,
    input  logic              tx_done,
    output logic              en,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        tx_data,
    output logic              trmt,
    output logic              busy,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(DEPTH - 1);

    dump_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W-1:0] cnt_reg;
    logic [1:0]        ch_reg;
    logic [7:0]        offset_reg;
    logic [7:0]        gain_reg;
    logic [7:0]        raw_reg;
    logic [7:0]        tx_data_reg;
    logic [7:0]        rdata_sel;
    logic [7:0]        corr;

    sample_corrector u_corr (
        .raw    (raw_reg),
        .offset (offset_reg),
        .gain   (gain_reg),
        .corr   (corr)
    );

    always_comb begin
        rdata_sel = rdata_ch1;
        case (ch_reg)
            CH_SEL_1:    rdata_sel = rdata_ch1;
            CH_SEL_2:    rdata_sel = rdata_ch2;
            CH_SEL_3:    rdata_sel = rdata_ch3;
            CH_SEL_ALT1: rdata_sel = rdata_ch1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (dump_start) state_next = READ;
            READ:    state_next = LATCH;
            LATCH:   state_next = CORR;
            CORR:    state_next = SEND;
            SEND:    state_next = WAIT_TX;
            WAIT_TX: if (tx_done) state_next = (cnt_reg == LAST_CNT) ? DONE : READ;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Command fields are captured once per dump so later changes cannot
    // alter the source channel or correction mid-stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_reg  <= '0;
            cnt_reg     <= '0;
            ch_reg      <= CH_SEL_1;
            offset_reg  <= 8'h00;
            gain_reg    <= 8'h00;
            raw_reg     <= 8'h00;
            tx_data_reg <= 8'h00;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (dump_start) begin
                        ch_reg     <= ch_sel;
                        offset_reg <= offset;
                        gain_reg   <= gain;
                        rd_ptr_reg <= trace_end + 1'b1;
                        cnt_reg    <= '0;
                    end
                end
                LATCH: raw_reg <= rdata_sel;
                CORR:  tx_data_reg <= corr;
                WAIT_TX: begin
                    if (tx_done && (cnt_reg != LAST_CNT)) begin
                        cnt_reg    <= cnt_reg + 1'b1;
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign en        = (state_reg == READ);
    assign trmt      = (state_reg == SEND);
    assign dump_done = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign addr      = rd_ptr_reg;
    assign tx_data   = tx_data_reg;

endmodule

// File: tb/tb_trace_dump.sv
// Self-checking bench for trace_dump: RAM and transmitter models, table of
// dump scenarios, randomized dumps, and a reset-mid-dump sequence.
module tb_trace_dump;

    localparam int DEPTH = 512;
    localparam int AW    = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic          dump_start;
    logic [1:0]    ch_sel;
    logic [AW-1:0] trace_end;
    logic [7:0]    offset, gain;
    logic [7:0]    rdata_ch1, rdata_ch2, rdata_ch3;
    logic          tx_done;
    logic          en, trmt, busy, dump_done;
    logic [AW-1:0] addr;
    logic [7:0]    tx_data;
    logic          tx_real = 1'b0;
    logic          tx_spur = 1'b0;

    assign tx_done = tx_real | tx_spur;

    always #5 clk = ~clk;

    trace_dump #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .dump_start (dump_start),
        .ch_sel     (ch_sel),
        .trace_end  (trace_end),
        .offset     (offset),
        .gain       (gain),
        .rdata_ch1  (rdata_ch1),
        .rdata_ch2  (rdata_ch2),
        .rdata_ch3  (rdata_ch3),
        .tx_done    (tx_done),
        .en         (en),
        .addr       (addr),
        .tx_data    (tx_data),
        .trmt       (trmt),
        .busy       (busy),
        .dump_done  (dump_done)
    );

    // Channel RAMs with one-cycle registered read.
    logic [7:0] ram1 [DEPTH];
    logic [7:0] ram2 [DEPTH];
    logic [7:0] ram3 [DEPTH];

    always @(posedge clk) begin
        if (en) begin
            rdata_ch1 <= ram1[addr];
            rdata_ch2 <= ram2[addr];
            rdata_ch3 <= ram3[addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model plus output monitor, sampled on the falling edge.
    int   tx_lat = 3;
    int   tx_left = 0;
    int   addr_q[$], data_q[$], en_cyc_q[$], trmt_cyc_q[$], txc_q[$];
    int   done_n = 0, done_cyc = -1, fall_cyc = -1;
    logic busy_prev = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            tx_left   = 0;
            tx_real   = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (en) begin
                addr_q.push_back(int'(addr));
                en_cyc_q.push_back(cyc);
            end
            if (trmt) begin
                data_q.push_back(int'(tx_data));
                trmt_cyc_q.push_back(cyc);
            end
            if (dump_done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (busy_prev && !busy) fall_cyc = cyc;
            busy_prev = busy;
            tx_real = 1'b0;
            if (tx_left > 0) begin
                tx_left--;
                if (tx_left == 0) begin
                    tx_real = 1'b1;
                    txc_q.push_back(cyc);
                end
            end
            if (trmt) tx_left = tx_lat;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cur_id   = 0;

    task automatic check_eq(input string nm, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s [dump %0d]: got %0d expected %0d", nm, cur_id, got, exp);
    endtask

    // Reference: correction computed from the arithmetic rules on plain ints.
    function automatic int ref_corr(input int raw, input int off, input int g);
        int s, p;
        s = raw + off;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        p = (s * g) / 128;
        if (p > 255) p = 255;
        return p;
    endfunction

    function automatic int ram_rd(input int ch, input int a);
        if (ch == 1) return int'(ram2[a]);
        if (ch == 2) return int'(ram3[a]);
        return int'(ram1[a]);
    endfunction

    task automatic fill_rams(input bit ident);
        for (int i = 0; i < DEPTH; i++) begin
            ram1[i] = 8'($urandom);
            ram2[i] = ident ? 8'(i) : 8'($urandom);
            ram3[i] = 8'($urandom);
        end
    endtask

    task automatic set_ram(input int ch, input int a, input int v);
        if (ch == 1) ram2[a] = 8'(v);
        else if (ch == 2) ram3[a] = 8'(v);
        else ram1[a] = 8'(v);
    endtask

    task automatic clear_mon();
        addr_q.delete(); data_q.delete(); en_cyc_q.delete();
        trmt_cyc_q.delete(); txc_q.delete();
        done_n = 0; done_cyc = -1; fall_cyc = -1;
    endtask

    task automatic run_dump(input int te, input int ch, input int off, input int g,
                            input int lat, input bit ident, input bit noisy,
                            input bit chk0, input int raw0, input int exp0);
        int guard, corr_cd, start_cyc, bad, exp_v;
        fill_rams(ident);
        if (chk0) set_ram(ch, (te + 1) % DEPTH, raw0);
        clear_mon();
        tx_lat = lat;
        @(negedge clk); #1;
        trace_end  = AW'(te);
        ch_sel     = 2'(ch);
        offset     = 8'(off);
        gain       = 8'(g);
        dump_start = 1'b1;
        start_cyc  = cyc;
        @(negedge clk); #1;
        dump_start = 1'b0;
        guard = 0;
        corr_cd = 0;
        while (done_n == 0 && guard < 20000) begin
            if (noisy) begin
                ch_sel     = 2'($urandom_range(0, 3));
                offset     = 8'($urandom);
                gain       = 8'($urandom);
                tx_spur    = 1'b0;
                dump_start = 1'b0;
                if (corr_cd > 0) begin
                    corr_cd--;
                    if (corr_cd == 0 && $urandom_range(0, 1) == 1) tx_spur = 1'b1;
                end
                if (en) begin
                    corr_cd = 2;
                    if ($urandom_range(0, 1) == 1) tx_spur = 1'b1;
                end
                if (busy && data_q.size() < 500 && $urandom_range(0, 15) == 0) dump_start = 1'b1;
            end
            @(negedge clk); #1;
            guard++;
        end
        tx_spur = 1'b0;
        dump_start = 1'b0;
        repeat (3) @(negedge clk);
        #1;

        check_eq("dump_finished", int'(guard < 20000), 1);
        check_eq("read_count", addr_q.size(), DEPTH);
        check_eq("byte_count", data_q.size(), DEPTH);
        if (addr_q.size() > 0) begin
            check_eq("first_addr", addr_q[0], (te + 1) % DEPTH);
            check_eq("last_addr", addr_q[addr_q.size() - 1], te % DEPTH);
        end
        bad = -1;
        for (int i = 0; i < addr_q.size() && i < DEPTH; i++)
            if (bad < 0 && addr_q[i] != (te + 1 + i) % DEPTH) bad = i;
        if (bad >= 0) check_eq("addr_seq", addr_q[bad], (te + 1 + bad) % DEPTH);
        else check_eq("addr_seq_mismatch_index", bad, -1);
        bad = -1;
        for (int i = 0; i < data_q.size() && i < DEPTH; i++)
            if (bad < 0 && data_q[i] != ref_corr(ram_rd(ch, (te + 1 + i) % DEPTH), off, g)) bad = i;
        if (bad >= 0) begin
            exp_v = ref_corr(ram_rd(ch, (te + 1 + bad) % DEPTH), off, g);
            check_eq("data_seq", data_q[bad], exp_v);
        end else begin
            check_eq("data_seq_mismatch_index", bad, -1);
        end
        if (chk0 && data_q.size() > 0) check_eq("first_byte", data_q[0], exp0);
        check_eq("done_count", done_n, 1);
        if (txc_q.size() > 0) check_eq("done_after_last_tx", done_cyc, txc_q[txc_q.size() - 1] + 1);
        check_eq("busy_fall", fall_cyc, done_cyc + 1);
        if (en_cyc_q.size() > 1 && trmt_cyc_q.size() > 0 && txc_q.size() > 0) begin
            check_eq("start_to_en", en_cyc_q[0] - start_cyc, 1);
            check_eq("start_to_trmt", trmt_cyc_q[0] - start_cyc, 4);
            check_eq("txdone_to_en", en_cyc_q[1] - txc_q[0], 1);
        end
    endtask

    typedef struct {
        int te; int ch; int off; int g; int lat; int ident; int raw0; int exp0;
    } vec_t;

    vec_t vecs[5];
    int   guard;

    initial begin
        vecs[0] = '{100, 1,   0, 128, 3, 1, 101,  101};
        vecs[1] = '{511, 0,  32, 128, 1, 0, 240,  255};
        vecs[2] = '{0,   2, -32, 128, 2, 0,  16,    0};
        vecs[3] = '{300, 3,   0, 255, 3, 0, 200,  255};
        vecs[4] = '{7,   1,   0,  64, 4, 0, 100,   50};

        rst = 1'b1; dump_start = 1'b0; ch_sel = 2'd0;
        trace_end = '0; offset = 8'h00; gain = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outputs", int'({en, trmt, busy, dump_done, addr, tx_data}), 0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            cur_id = i;
            run_dump(vecs[i].te, vecs[i].ch, vecs[i].off, vecs[i].g, vecs[i].lat,
                     vecs[i].ident != 0, 1'b0, 1'b1, vecs[i].raw0, vecs[i].exp0);
        end

        for (int i = 0; i < 3; i++) begin
            cur_id = 5 + i;
            run_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)),
                     int'($urandom_range(1, 5)), 1'b0, (i == 0), 1'b0, 0, 0);
        end

        // Reset after the 37th byte has been accepted.
        cur_id = 8;
        fill_rams(1'b0);
        clear_mon();
        tx_lat = 3;
        @(negedge clk); #1;
        trace_end = AW'(200); ch_sel = 2'd0; offset = 8'h00; gain = 8'h80;
        dump_start = 1'b1;
        @(negedge clk); #1;
        dump_start = 1'b0;
        guard = 0;
        while (txc_q.size() < 37 && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
        end
        check_eq("reached_byte37", int'(txc_q.size() >= 37), 1);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("midreset_outputs", int'({en, trmt, busy, dump_done, addr, tx_data}), 0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check_eq("no_done_after_reset", done_n, 0);
        check_eq("idle_after_reset", int'(busy), 0);

        cur_id = 9;
        run_dump(200, 0, 0, 128, 2, 1'b0, 1'b0, 1'b0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
